// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the shared FIFO write port
// Optional statistics counters are enabled with the FIFO_WR_ARB_STATS_EN macro.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          fifo_full,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0]         stat_words,
  output logic [15:0]                   stat_stall,
`endif
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [0:0] {S_IDLE, S_BURST} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic               in_burst;
  logic               g_valid;
  logic               wr_fire;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!sel_found && req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // Write-port steering: only the granted producer sees ready, and never while full or in reset
  always_comb begin
    in_burst     = (state_q == S_BURST);
    g_valid      = |(req_valid & grant_q);
    wr_fire      = in_burst & g_valid & ~fifo_full & ~rst;
    req_ready    = (in_burst & ~fifo_full & ~rst) ? grant_q : '0;
    fifo_data_in = in_burst ? req_data[gidx_q*FIFO_WIDTH +: FIFO_WIDTH] : '0;
  end

  assign fifo_wr_en = wr_fire;
  assign grant      = grant_q;

  // Next-state logic: grant from IDLE, count/release/stall in BURST
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d  = S_BURST;
          grant_d  = NUM_REQ'(1) << sel_idx;
          gidx_d   = sel_idx;
          rr_ptr_d = sel_idx;
          cnt_d    = '0;
        end
      end
      S_BURST: begin
        if (wr_fire) begin
          if (cnt_q == LAST_CNT) begin
            state_d = S_IDLE;
            grant_d = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (!g_valid) begin
          // A gap from the producer ends its burst; a full FIFO alone only stalls
          state_d = S_IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Arbiter state registers; reset points rr_ptr at the last requester so requester 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] words_q, words_d;
  logic [15:0]           stall_q, stall_d;

  // Saturating per-requester word counters and a stall-cycle counter
  always_comb begin
    words_d = words_q;
    stall_d = stall_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_fire && gidx_q == IDX_W'(i) && words_q[i*16 +: 16] != 16'hFFFF) begin
        words_d[i*16 +: 16] = words_q[i*16 +: 16] + 16'd1;
      end
    end
    if (in_burst && fifo_full && g_valid && !rst && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Statistics registers, cleared with the arbiter
  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      words_q <= words_d;
      stall_q <= stall_d;
    end
  end

  assign stat_words = words_q;
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [15:0] fifo_data_in;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [63:0] stat_words;
  logic [15:0] stat_stall;
`endif

  fifo_wr_arbiter #(.NUM_REQ(4), .FIFO_WIDTH(16), .MAX_BURST(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .grant        (grant),
    .fifo_full    (fifo_full),
`ifdef FIFO_WR_ARB_STATS_EN
    .stat_words   (stat_words),
    .stat_stall   (stat_stall),
`endif
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       full;
    logic [3:0] grant;
    logic       wr_en;
    logic [3:0] ready;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] exp_q[$];
  int          prod_left[4];
  int          word_cnt[4];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input int r, input int w);
    logic [7:0] hi;
    hi = 8'hA0 + 8'(16 * r);
    return {hi, 8'(w)};
  endfunction

  task automatic drive_outputs();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]          = (prod_left[i] > 0);
      req_data[i*16 +: 16]  = word_of(i, word_cnt[i]);
    end
  endtask

  // Advance one clock; producers step their word after an accepted handshake
  task automatic drive_edge();
    logic [3:0] xf;
    xf = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (xf[i]) begin
        word_cnt[i]++;
        prod_left[i]--;
      end
    end
    drive_outputs();
  endtask

  function automatic void add_row(input logic r, input logic f, input logic [3:0] g,
                                  input logic w, input logic [3:0] rd);
    vec_t v;
    v.rst = r; v.full = f; v.grant = g; v.wr_en = w; v.ready = rd;
    tbl.push_back(v);
  endfunction

  function automatic void push_burst(input int r, input int first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(word_of(r, first + k));
  endfunction

  // Fill table and scoreboard for nb back-to-back rotating bursts of 4
  function automatic void rotation(input int nb);
    for (int b = 0; b < nb; b++) begin
      add_row(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
      for (int p = 0; p < 4; p++) add_row(1'b0, 1'b0, 4'(1 << (b % 4)), 1'b1, 4'(1 << (b % 4)));
      push_burst(b % 4, 4 * (b / 4), 4);
    end
  endfunction

  task automatic run_table(input string tag);
    for (int j = 0; j < tbl.size(); j++) begin
      rst       = tbl[j].rst;
      fifo_full = tbl[j].full;
      @(negedge clk);
      check($sformatf("%s[%0d].grant", tag, j), 32'(grant), 32'(tbl[j].grant));
      check($sformatf("%s[%0d].wr_en", tag, j), 32'(fifo_wr_en), 32'(tbl[j].wr_en));
      check($sformatf("%s[%0d].ready", tag, j), 32'(req_ready), 32'(tbl[j].ready));
      if (tbl[j].grant == 4'b0000)
        check($sformatf("%s[%0d].data_idle", tag, j), 32'(fifo_data_in), 32'h0);
      drive_edge();
    end
    tbl.delete();
  endtask

  task automatic set_idle_producers();
    for (int i = 0; i < 4; i++) prod_left[i] = 0;
    drive_outputs();
  endtask

  // Scoreboard: every FIFO write must be the next expected word, and never while full
  always @(negedge clk) begin
    if (fifo_wr_en) begin
      check("wr_while_full", 32'(fifo_full), 32'h0);
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", 32'(fifo_data_in), 32'hFFFF_FFFF);
      end else begin
        check("sb_data", 32'(fifo_data_in), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      prod_left[i] = 0;
      word_cnt[i]  = 0;
    end
    drive_outputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset.grant", 32'(grant), 32'h0);
    check("reset.ready", 32'(req_ready), 32'h0);
    check("reset.wr_en", 32'(fifo_wr_en), 32'h0);
    check("reset.data", 32'(fifo_data_in), 32'h0);
    drive_edge();

    // 1: all requesters busy, grants rotate 0,1,2,3,0
    for (int i = 0; i < 4; i++) prod_left[i] = 100;
    drive_outputs();
    rotation(5);
    run_table("rot");
    set_idle_producers();

    // 2: lone requester 2 with 10 words -> bursts 4,4,2
    word_cnt[2] = 0; prod_left[2] = 10;
    drive_outputs();
    push_burst(2, 0, 10);
    for (int b = 0; b < 2; b++) begin
      add_row(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
      for (int p = 0; p < 4; p++) add_row(1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100);
    end
    add_row(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    add_row(1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100);
    add_row(1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100);
    add_row(1'b0, 1'b0, 4'b0100, 1'b0, 4'b0100);
    add_row(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    run_table("solo");

    // 3: requester 1 stalled by a full FIFO for 3 cycles after its 2nd word
    word_cnt[1] = 0; prod_left[1] = 4;
    drive_outputs();
    push_burst(1, 0, 4);
    add_row(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    add_row(1'b0, 1'b0, 4'b0010, 1'b1, 4'b0010);
    add_row(1'b0, 1'b0, 4'b0010, 1'b1, 4'b0010);
    for (int s = 0; s < 3; s++) add_row(1'b0, 1'b1, 4'b0010, 1'b0, 4'b0000);
    add_row(1'b0, 1'b0, 4'b0010, 1'b1, 4'b0010);
    add_row(1'b0, 1'b0, 4'b0010, 1'b1, 4'b0010);
    add_row(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    run_table("stall");

    // 4: requester 3 drops valid after one word, then requester 0 is served
    word_cnt[3] = 0; prod_left[3] = 1;
    word_cnt[0] = 0; prod_left[0] = 3;
    drive_outputs();
    push_burst(3, 0, 1);
    push_burst(0, 0, 3);
    add_row(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    add_row(1'b0, 1'b0, 4'b1000, 1'b1, 4'b1000);
    add_row(1'b0, 1'b0, 4'b1000, 1'b0, 4'b1000);
    add_row(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    for (int p = 0; p < 3; p++) add_row(1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001);
    add_row(1'b0, 1'b0, 4'b0001, 1'b0, 4'b0001);
    add_row(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    run_table("gap");

    // 5: reset in the middle of requester 1's burst, at its third word
    word_cnt[1] = 0; prod_left[1] = 10;
    drive_outputs();
    push_burst(1, 0, 2);
    add_row(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    add_row(1'b0, 1'b0, 4'b0010, 1'b1, 4'b0010);
    add_row(1'b0, 1'b0, 4'b0010, 1'b1, 4'b0010);
    add_row(1'b1, 1'b0, 4'b0010, 1'b0, 4'b0000);
    run_table("rst_pre");
    set_idle_producers();
    word_cnt[0] = 0; prod_left[0] = 2;
    word_cnt[2] = 0; prod_left[2] = 2;
    drive_outputs();
    push_burst(0, 0, 2);
    push_burst(2, 0, 2);
    add_row(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    add_row(1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001);
    add_row(1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001);
    add_row(1'b0, 1'b0, 4'b0001, 1'b0, 4'b0001);
    add_row(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    add_row(1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100);
    add_row(1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100);
    add_row(1'b0, 1'b0, 4'b0100, 1'b0, 4'b0100);
    add_row(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    run_table("rst_post");

`ifdef FIFO_WR_ARB_STATS_EN
    // 6: three full rotations, then read the counters
    add_row(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
    run_table("st_rst");
    for (int i = 0; i < 4; i++) begin
      word_cnt[i]  = 0;
      prod_left[i] = 100;
    end
    drive_outputs();
    rotation(12);
    run_table("st_rot");
    set_idle_producers();
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("stat_words[%0d]", i), 32'(stat_words[i*16 +: 16]), 32'd12);
    check("stat_stall", 32'(stat_stall), 32'd0);
`endif

    @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
